// File: rtl/if_stage_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// BRANCH_DELAY_SLOT_EN is consumed by if_stage.sv; nothing in this package depends on it.
package if_stage_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic [2:0] {
      PC_SEL_RESET,
      PC_SEL_BRANCH,
      PC_SEL_JUMP,
      PC_SEL_HOLD,
      PC_SEL_SEQ
   } pc_sel_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: reset and flush load a bubble, enable low holds.
// The flush input wins over a deasserted enable so a redirect can squash a stalled slot.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        flush,
   input  logic [31:0] pc4_in,
   input  logic [31:0] instr_in,
   input  logic        valid_in,
   output logic [31:0] pc4,
   output logic [31:0] instr,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pc4   <= '0;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (enable) begin
         pc4   <= pc4_in;
         instr <= instr_in;
         valid <= valid_in;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to keep the instruction after a jump (delay slot) and never kill ID.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall,
   input  logic        Branch_fc,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] Instr_in,
   output logic [31:0] PC,
   output logic [31:0] IFID_PC4,
   output logic [31:0] IFID_Instr,
   output logic        IFID_Valid,
   output logic        Flush_ID
);

   pc_sel_e     pc_sel;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic        ifid_flush;
   logic        ifid_enable;

   assign pc_plus4 = PC + INSTR_BYTES;

   // A branch outranks a same-cycle jump because the jump sits on the squashed path.
   always_comb begin
      pc_sel = PC_SEL_SEQ;
      if (rst)            pc_sel = PC_SEL_RESET;
      else if (Branch_fc) pc_sel = PC_SEL_BRANCH;
      else if (Jump)      pc_sel = PC_SEL_JUMP;
      else if (Stall)     pc_sel = PC_SEL_HOLD;
   end

   always_comb begin
      pc_next = pc_plus4;
      unique case (pc_sel)
         PC_SEL_RESET:  pc_next = RESET_PC;
         PC_SEL_BRANCH: pc_next = word_align(BranchTarget);
         PC_SEL_JUMP:   pc_next = word_align(JumpTarget);
         PC_SEL_HOLD:   pc_next = PC;
         PC_SEL_SEQ:    pc_next = pc_plus4;
         default:       pc_next = pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      PC <= pc_next;
   end

   assign ifid_enable = ~Stall;

`ifdef BRANCH_DELAY_SLOT_EN
   assign ifid_flush = Branch_fc;
   assign Flush_ID   = 1'b0;
`else
   assign ifid_flush = Branch_fc | Jump;
   assign Flush_ID   = Branch_fc & ~rst;
`endif

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .enable   (ifid_enable),
      .flush    (ifid_flush),
      .pc4_in   (pc_plus4),
      .instr_in (Instr_in),
      .valid_in (1'b1),
      .pc4      (IFID_PC4),
      .instr    (IFID_Instr),
      .valid    (IFID_Valid)
   );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, branch/jump redirect,
// priority, reset during redirect and PC wrap (second instance near the top of memory).
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_fc;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;

   logic [31:0] pc, ifid_pc4, ifid_instr;
   logic        ifid_valid, flush_id;
   logic [31:0] pc_t, ifid_pc4_t, ifid_instr_t;
   logic        ifid_valid_t, flush_id_t;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk(clk), .rst(rst), .Stall(stall), .Branch_fc(branch_fc),
      .BranchTarget(branch_target), .Jump(jump), .JumpTarget(jump_target),
      .Instr_in(pc), .PC(pc), .IFID_PC4(ifid_pc4), .IFID_Instr(ifid_instr),
      .IFID_Valid(ifid_valid), .Flush_ID(flush_id)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_top (
      .clk(clk), .rst(rst), .Stall(stall), .Branch_fc(branch_fc),
      .BranchTarget(branch_target), .Jump(jump), .JumpTarget(jump_target),
      .Instr_in(pc_t), .PC(pc_t), .IFID_PC4(ifid_pc4_t), .IFID_Instr(ifid_instr_t),
      .IFID_Valid(ifid_valid_t), .Flush_ID(flush_id_t)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   initial begin
      rst = 1'b1; stall = 1'b0; branch_fc = 1'b1; branch_target = 32'h0000_3100;
      jump = 1'b0; jump_target = 32'h0;
      #1;
      check("flush_in_reset", {31'd0, flush_id}, 32'd0);
      step();
      check("rst_pc", pc, 32'h0000_3000);
      check("rst_pc4", ifid_pc4, 32'h0);
      check("rst_instr", ifid_instr, 32'h0);
      check("rst_valid", {31'd0, ifid_valid}, 32'd0);
      check("rst_pc_top", pc_t, 32'hFFFF_FFF8);

      branch_fc = 1'b0;
      rst = 1'b0;
      #1;
      check("seq0_pc", pc, 32'h0000_3000);
      step();
      check("seq1_pc", pc, 32'h0000_3004);
      check("seq1_pc4", ifid_pc4, 32'h0000_3004);
      check("seq1_instr", ifid_instr, 32'h0000_3000);
      check("seq1_valid", {31'd0, ifid_valid}, 32'd1);
      step();
      check("seq2_pc", pc, 32'h0000_3008);
      check("seq2_pc4", ifid_pc4, 32'h0000_3008);

      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_pc", pc, 32'h0000_3008);
         check("stall_pc4", ifid_pc4, 32'h0000_3008);
         check("stall_instr", ifid_instr, 32'h0000_3004);
         check("stall_valid", {31'd0, ifid_valid}, 32'd1);
      end
      stall = 1'b0;
      step();
      check("resume_pc", pc, 32'h0000_300C);
      check("resume_pc4", ifid_pc4, 32'h0000_300C);
      check("resume_instr", ifid_instr, 32'h0000_3008);
      step();
      check("seq4_pc", pc, 32'h0000_3010);

      branch_fc = 1'b1; branch_target = 32'h0000_3100; stall = 1'b1;
      #1;
      check("br_flush_id", {31'd0, flush_id}, DS ? 32'd0 : 32'd1);
      step();
      check("br_pc", pc, 32'h0000_3100);
      check("br_valid", {31'd0, ifid_valid}, 32'd0);
      check("br_instr", ifid_instr, 32'h0);
      check("br_pc4", ifid_pc4, 32'h0);
      branch_fc = 1'b0; stall = 1'b0;
      step();
      check("post_br_pc", pc, 32'h0000_3104);
      check("post_br_instr", ifid_instr, 32'h0000_3100);

      jump = 1'b1; jump_target = 32'h0000_3203;
      #1;
      check("jmp_flush_id", {31'd0, flush_id}, 32'd0);
      step();
      check("jmp_pc", pc, 32'h0000_3200);
      check("jmp_valid", {31'd0, ifid_valid}, DS ? 32'd1 : 32'd0);
      check("jmp_instr", ifid_instr, DS ? 32'h0000_3104 : 32'h0);
      check("jmp_pc4", ifid_pc4, DS ? 32'h0000_3108 : 32'h0);
      jump = 1'b0;
      step();
      check("post_jmp_pc", pc, 32'h0000_3204);

      branch_fc = 1'b1; branch_target = 32'h0000_3100;
      jump = 1'b1; jump_target = 32'h0000_3200;
      step();
      check("br_jmp_pc", pc, 32'h0000_3100);
      check("br_jmp_valid", {31'd0, ifid_valid}, 32'd0);
      jump = 1'b0;

      // Reset lands on top of a branch request: the branch must vanish.
      branch_fc = 1'b1; branch_target = 32'h0000_3100; rst = 1'b1;
      step();
      check("rst_br_pc", pc, 32'h0000_3000);
      check("rst_br_valid", {31'd0, ifid_valid}, 32'd0);
      check("rst_br_pc_top", pc_t, 32'hFFFF_FFF8);
      rst = 1'b0; branch_fc = 1'b0;
      step();
      check("rst_br_next_pc", pc, 32'h0000_3004);
      check("wrap1_pc", pc_t, 32'hFFFF_FFFC);
      step();
      check("wrap2_pc", pc_t, 32'h0000_0000);
      check("wrap2_pc4", ifid_pc4_t, 32'h0000_0000);
      check("wrap2_instr", ifid_instr_t, 32'hFFFF_FFFC);
      check("wrap2_valid", {31'd0, ifid_valid_t}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
